// File: rtl/csm_cmd_issuer.sv
// csm_cmd_issuer
//   Front-end stage for the computation-storage model. Command packets
//   (RD/WR/ADD/SUB) are accepted over a valid/ready handshake into an in-order
//   command FIFO. At most one command per cycle is issued onto the storage
//   model's registered cmd/addA/addB/addC/DQ_i bus. Idle cycles drive a read of
//   address 0 with every field zero. DQ_o is captured only for genuine reads
//   and is returned through a show-ahead response FIFO with backpressure.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              command handshake
//   in_cmd/in_addA/B/C/in_data     command packet (00=RD 01=WR 10=ADD 11=SUB)
//   cmd/addA/addB/addC/DQ_i        registered drive to the storage model
//   DQ_o                           read data from the storage model
//   rsp_valid/rsp_ready/rsp_data   response handshake (data valid at FIFO head)
//   cmd_count                      command FIFO occupancy
//   busy                           commands queued, reads in flight, or responses held
module csm_cmd_issuer #(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_LENGTH = 4,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_cmd,
  input  logic [MEM_LENGTH-1:0]        in_addA,
  input  logic [MEM_LENGTH-1:0]        in_addB,
  input  logic [MEM_LENGTH-1:0]        in_addC,
  input  logic [MEM_WIDTH-1:0]         in_data,
  output logic [1:0]                   cmd,
  output logic [MEM_LENGTH-1:0]        addA,
  output logic [MEM_LENGTH-1:0]        addB,
  output logic [MEM_LENGTH-1:0]        addC,
  output logic [MEM_WIDTH-1:0]         DQ_i,
  input  logic [MEM_WIDTH-1:0]         DQ_o,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [MEM_WIDTH-1:0]         rsp_data,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         busy
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int CPW = CAW + 1;
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int RPW = RAW + 1;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef struct packed {
    logic [1:0]            op;
    logic [MEM_LENGTH-1:0] a;
    logic [MEM_LENGTH-1:0] b;
    logic [MEM_LENGTH-1:0] c;
    logic [MEM_WIDTH-1:0]  data;
  } cmd_entry_t;

  cmd_entry_t           cmd_mem [CMD_DEPTH];
  logic [MEM_WIDTH-1:0] rsp_mem [RSP_DEPTH];

  logic [CPW-1:0]        cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [RPW-1:0]        rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [MEM_LENGTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, add_c_q, add_c_d;
  logic [MEM_WIDTH-1:0]  dq_i_q, dq_i_d;
  // rd_drv: a genuine RD is on the bus this cycle.
  // rd_inflight: its data is on DQ_o this cycle and is captured at the next edge.
  logic                  rd_drv_q, rd_drv_d, rd_inflight_q, rd_inflight_d;

  logic                  cmd_full, cmd_empty, in_push, issue;
  logic                  rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [RPW-1:0]        rsp_count;
  logic [RPW:0]          reads_owed;
  cmd_entry_t            head, push_entry;

  always_comb begin
    cmd_full   = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                 (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
    cmd_empty  = (cmd_wr_q == cmd_rd_q);
    rsp_full   = (rsp_wr_q[RAW] != rsp_rd_q[RAW]) &&
                 (rsp_wr_q[RAW-1:0] == rsp_rd_q[RAW-1:0]);
    rsp_empty  = (rsp_wr_q == rsp_rd_q);
    rsp_count  = rsp_wr_q - rsp_rd_q;
    head       = cmd_mem[cmd_rd_q[CAW-1:0]];
    push_entry = '{op: in_cmd, a: in_addA, b: in_addB, c: in_addC, data: in_data};

    // Every read already on the bus or on DQ_o holds a response slot, so a
    // new RD may only go out if the FIFO can still absorb all of them.
    reads_owed = {1'b0, rsp_count} + (RPW+1)'(rd_drv_q) + (RPW+1)'(rd_inflight_q);

    in_push  = in_valid && !cmd_full;
    issue    = !cmd_empty && ((head.op != OP_RD) || (reads_owed < (RPW+1)'(RSP_DEPTH)));
    rsp_push = rd_inflight_q;
    rsp_pop  = !rsp_empty && rsp_ready;

    cmd_wr_d = in_push ? cmd_wr_q + CPW'(1) : cmd_wr_q;
    cmd_rd_d = issue   ? cmd_rd_q + CPW'(1) : cmd_rd_q;
    rsp_wr_d = rsp_push ? rsp_wr_q + RPW'(1) : rsp_wr_q;
    rsp_rd_d = rsp_pop  ? rsp_rd_q + RPW'(1) : rsp_rd_q;

    // Idle pattern unless a command is popped this edge.
    cmd_d   = OP_RD;
    add_a_d = '0;
    add_b_d = '0;
    add_c_d = '0;
    dq_i_d  = '0;
    if (issue) begin
      cmd_d   = head.op;
      add_a_d = head.a;
      add_b_d = head.b;
      add_c_d = head.c;
      dq_i_d  = (head.op == OP_WR) ? head.data : '0;
    end
    rd_drv_d      = issue && (head.op == OP_RD);
    rd_inflight_d = rd_drv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q      <= '0;
      cmd_rd_q      <= '0;
      rsp_wr_q      <= '0;
      rsp_rd_q      <= '0;
      cmd_q         <= OP_RD;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_c_q       <= '0;
      dq_i_q        <= '0;
      rd_drv_q      <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      cmd_wr_q      <= cmd_wr_d;
      cmd_rd_q      <= cmd_rd_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rd_q      <= rsp_rd_d;
      cmd_q         <= cmd_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      add_c_q       <= add_c_d;
      dq_i_q        <= dq_i_d;
      rd_drv_q      <= rd_drv_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Storage arrays carry no reset; the pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (in_push) cmd_mem[cmd_wr_q[CAW-1:0]] <= push_entry;
    if (rsp_push) rsp_mem[rsp_wr_q[RAW-1:0]] <= DQ_o;
  end

  rsp_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));

  assign in_ready  = !cmd_full;
  assign cmd       = cmd_q;
  assign addA      = add_a_q;
  assign addB      = add_b_q;
  assign addC      = add_c_q;
  assign DQ_i      = dq_i_q;
  assign rsp_valid = !rsp_empty;
  assign rsp_data  = rsp_empty ? '0 : rsp_mem[rsp_rd_q[RAW-1:0]];
  assign cmd_count = cmd_wr_q - cmd_rd_q;
  assign busy      = !cmd_empty || rd_drv_q || rd_inflight_q || !rsp_empty;

endmodule
